// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot dispatch slice.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_BUSY = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_e;

    localparam int unsigned DEF_NE  = 4;
    localparam int unsigned DEF_FPW = 27;
    localparam int unsigned DEF_AW  = 12;
    localparam int unsigned DEF_IW  = 8;

    // Coordinate format: sign, integer and fraction bits.
    localparam int unsigned FP_S = 1;
    localparam int unsigned FP_I = 4;

    function automatic int unsigned fp_frac_bits(input int unsigned fpw);
        return fpw - FP_S - FP_I;
    endfunction

    localparam int unsigned FP_F = fp_frac_bits(DEF_FPW);

endpackage

// File: rtl/mandelbrot_dispatch_if.sv
// Generator, engine and framebuffer-writer signals of the dispatcher.
interface mandelbrot_dispatch_if
    import mandelbrot_pkg::*;
#(
    parameter int unsigned NE  = DEF_NE,
    parameter int unsigned FPW = DEF_FPW,
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned IW  = DEF_IW
);
    logic               in_vld;
    logic               in_rdy;
    logic [FPW-1:0]     in_x;
    logic [FPW-1:0]     in_y;
    logic [AW-1:0]      in_adr;

    logic [NE-1:0]      eng_start;
    logic [FPW-1:0]     eng_x;
    logic [FPW-1:0]     eng_y;
    logic [NE-1:0]      eng_done;
    logic [NE*IW-1:0]   eng_niter;

    logic               out_vld;
    logic               out_rdy;
    logic [AW-1:0]      out_adr;
    logic [IW-1:0]      out_niter;

    // Dispatcher side.
    modport master (
        input  in_vld, in_x, in_y, in_adr,
        output in_rdy,
        output eng_start, eng_x, eng_y,
        input  eng_done, eng_niter,
        output out_vld, out_adr, out_niter,
        input  out_rdy
    );

    // Environment side: generator, engines and result consumer.
    modport slave (
        output in_vld, in_x, in_y, in_adr,
        input  in_rdy,
        input  eng_start, eng_x, eng_y,
        output eng_done, eng_niter,
        input  out_vld, out_adr, out_niter,
        output out_rdy
    );

endinterface

// File: rtl/mandelbrot_rr_arb.sv
// Combinational round-robin first-match: first set req at or after ptr, wrapping.
module mandelbrot_rr_arb #(
    parameter int unsigned NE = 4
) (
    input  logic [NE-1:0]         req,
    input  logic [$clog2(NE)-1:0] ptr,
    output logic [NE-1:0]         grant,
    output logic [$clog2(NE)-1:0] idx,
    output logic                  any
);
    localparam int unsigned PW = $clog2(NE);

    logic [PW:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < int'(NE); i++) begin
            // Extra bit lets ptr + i exceed NE before folding back into range.
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NE)) begin
                cand = cand - (PW+1)'(NE);
            end
            if (!any && req[cand[PW-1:0]]) begin
                any                = 1'b1;
                idx                = cand[PW-1:0];
                grant[cand[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_dispatch.sv
// Round-robin scheduler between the coordinate generator, NE iteration engines
// and the framebuffer writer; each engine's pixel address is held in a tag table.
module mandelbrot_dispatch
    import mandelbrot_pkg::*;
#(
    parameter int unsigned NE  = DEF_NE,
    parameter int unsigned FPW = DEF_FPW,
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned IW  = DEF_IW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    mandelbrot_dispatch_if.master bus,
    output logic                  busy,
    output logic                  err
);
    localparam int unsigned PW = $clog2(NE);

    eng_state_e      state_q [NE];
    eng_state_e      state_d [NE];
    logic [AW-1:0]   tag_adr_q [NE];
    logic [IW-1:0]   res_niter_q [NE];

    logic [NE-1:0]   idle_req;
    logic [NE-1:0]   done_req;
    logic [NE-1:0]   done_ok;
    logic [NE-1:0]   d_grant;
    logic [NE-1:0]   c_grant;
    logic [PW-1:0]   d_idx;
    logic [PW-1:0]   c_idx;
    logic            d_any;
    logic            c_any;

    logic [PW-1:0]   dp_q, dp_d;
    logic [PW-1:0]   cp_q, cp_d;
    logic [NE-1:0]   eng_start_q, eng_start_d;
    logic [FPW-1:0]  eng_x_q, eng_y_q;
    logic            out_vld_q;
    logic [AW-1:0]   out_adr_q;
    logic [IW-1:0]   out_niter_q;
    logic            err_q, err_d;

    logic            xfer;
    logic            out_load;
    logic            collect;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(NE - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < int'(NE); k++) begin
            idle_req[k] = (state_q[k] == ENG_IDLE);
            done_req[k] = (state_q[k] == ENG_DONE);
        end
    end

    mandelbrot_rr_arb #(
        .NE (NE)
    ) u_dispatch_arb (
        .req   (idle_req),
        .ptr   (dp_q),
        .grant (d_grant),
        .idx   (d_idx),
        .any   (d_any)
    );

    mandelbrot_rr_arb #(
        .NE (NE)
    ) u_collect_arb (
        .req   (done_req),
        .ptr   (cp_q),
        .grant (c_grant),
        .idx   (c_idx),
        .any   (c_any)
    );

    // in_rdy depends on registered state only, never on in_vld.
    assign bus.in_rdy = |idle_req;
    assign xfer       = bus.in_vld && bus.in_rdy;
    assign out_load   = !out_vld_q || bus.out_rdy;
    assign collect    = out_load && c_any;

    always_comb begin
        state_d     = state_q;
        done_ok     = '0;
        err_d       = err_q;
        dp_d        = dp_q;
        cp_d        = cp_q;
        eng_start_d = '0;

        if (xfer) begin
            eng_start_d = d_grant;
            dp_d        = next_ptr(d_idx);
        end
        if (collect) begin
            cp_d = next_ptr(c_idx);
        end

        for (int k = 0; k < int'(NE); k++) begin
            // A done pulse alongside the engine's own start pulse is spurious.
            done_ok[k] = bus.eng_done[k] && (state_q[k] == ENG_BUSY) && !eng_start_q[k];
            if (bus.eng_done[k] && !done_ok[k]) begin
                err_d = 1'b1;
            end
            case (state_q[k])
                ENG_IDLE: if (xfer && d_grant[k])    state_d[k] = ENG_BUSY;
                ENG_BUSY: if (done_ok[k])            state_d[k] = ENG_DONE;
                ENG_DONE: if (collect && c_grant[k]) state_d[k] = ENG_IDLE;
                default:                             state_d[k] = ENG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NE); k++) begin
                state_q[k] <= ENG_IDLE;
            end
            dp_q        <= '0;
            cp_q        <= '0;
            eng_start_q <= '0;
            err_q       <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            dp_q        <= dp_d;
            cp_q        <= cp_d;
            eng_start_q <= eng_start_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NE); k++) begin
                tag_adr_q[k]   <= '0;
                res_niter_q[k] <= '0;
            end
            eng_x_q <= '0;
            eng_y_q <= '0;
        end else if (clk_en) begin
            if (xfer) begin
                eng_x_q <= bus.in_x;
                eng_y_q <= bus.in_y;
            end
            for (int k = 0; k < int'(NE); k++) begin
                if (xfer && d_grant[k]) begin
                    tag_adr_q[k] <= bus.in_adr;
                end
                if (done_ok[k]) begin
                    res_niter_q[k] <= bus.eng_niter[k*IW +: IW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_adr_q   <= '0;
            out_niter_q <= '0;
        end else if (clk_en && out_load) begin
            if (c_any) begin
                out_vld_q   <= 1'b1;
                out_adr_q   <= tag_adr_q[c_idx];
                out_niter_q <= res_niter_q[c_idx];
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.eng_x     = eng_x_q;
    assign bus.eng_y     = eng_y_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.out_adr   = out_adr_q;
    assign bus.out_niter = out_niter_q;
    assign busy          = !(&idle_req) || out_vld_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mandelbrot_dispatch.sv
// Directed, table-driven bench for mandelbrot_dispatch with hand-computed expectations.
module tb_mandelbrot_dispatch;

    localparam int unsigned NE  = 4;
    localparam int unsigned FPW = 27;
    localparam int unsigned AW  = 12;
    localparam int unsigned IW  = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;
    logic busy;
    logic err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0]  adr;
        logic [FPW-1:0] x;
        logic [FPW-1:0] y;
        logic           rdy;
        logic [NE-1:0]  start;
    } fill_vec_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [IW-1:0] niter;
    } out_vec_t;

    fill_vec_t fill_tbl [5];
    out_vec_t  simul_tbl [4];
    out_vec_t  drain_tbl [4];

    mandelbrot_dispatch_if #(.NE(NE), .FPW(FPW), .AW(AW), .IW(IW)) bus ();

    mandelbrot_dispatch #(
        .NE  (NE),
        .FPW (FPW),
        .AW  (AW),
        .IW  (IW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_vld    = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_adr    = '0;
        bus.eng_done  = '0;
        bus.eng_niter = '0;
        bus.out_rdy   = 1'b1;
        clk_en        = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic finish_eng(input logic [NE-1:0] mask, input logic [NE*IW-1:0] niter);
        bus.eng_done  = mask;
        bus.eng_niter = niter;
        tick();
        bus.eng_done  = '0;
    endtask

    task automatic dispatch(input logic [AW-1:0] adr, input logic [NE-1:0] exp_start,
                            input string name);
        bus.in_vld = 1'b1;
        bus.in_adr = adr;
        bus.in_x   = FPW'(adr) + 27'h0100000;
        bus.in_y   = FPW'(adr) + 27'h0200000;
        tick();
        bus.in_vld = 1'b0;
        check(name, bus.eng_start, exp_start);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            fill_tbl[i].adr   = AW'(i);
            fill_tbl[i].x     = 27'h0100000 + FPW'(i);
            fill_tbl[i].y     = 27'h0200000 + FPW'(i);
            fill_tbl[i].rdy   = (i < 4);
            fill_tbl[i].start = (i < 4) ? NE'(1 << i) : '0;
        end
        simul_tbl[0] = '{adr: 12'd12, niter: 8'h42};
        simul_tbl[1] = '{adr: 12'd13, niter: 8'h43};
        simul_tbl[2] = '{adr: 12'd20, niter: 8'h40};
        simul_tbl[3] = '{adr: 12'd21, niter: 8'h41};
        for (int i = 0; i < 4; i++) begin
            drain_tbl[i].adr   = 12'd30 + AW'(i);
            drain_tbl[i].niter = 8'h50 + IW'(i);
        end

        // Reset state and single pixel
        do_reset();
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_eng_x", bus.eng_x, 0);
        check("rst_eng_y", bus.eng_y, 0);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_adr", bus.out_adr, 0);
        check("rst_out_niter", bus.out_niter, 0);
        check("rst_err", err, 0);
        check("rst_in_rdy", bus.in_rdy, 1);
        check("rst_busy", busy, 0);

        clk_en     = 1'b0;
        bus.in_vld = 1'b1;
        bus.in_x   = 27'h3bd5555;
        bus.in_y   = 27'h3e00000;
        bus.in_adr = 12'd5;
        tick();
        check("clken_low_start", bus.eng_start, 0);
        check("clken_low_busy", busy, 0);
        clk_en = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        check("single_start", bus.eng_start, 4'b0001);
        check("single_x", bus.eng_x, 27'h3bd5555);
        check("single_y", bus.eng_y, 27'h3e00000);
        check("single_busy", busy, 1);
        tick();
        check("single_start_clr", bus.eng_start, 0);
        repeat (8) tick();
        finish_eng(4'b0001, 32'h0000_002a);
        check("single_vld_early", bus.out_vld, 0);
        tick();
        check("single_vld", bus.out_vld, 1);
        check("single_adr", bus.out_adr, 5);
        check("single_niter", bus.out_niter, 8'h2a);
        tick();
        check("single_vld_clr", bus.out_vld, 0);
        check("single_idle", busy, 0);
        check("single_err", err, 0);

        // Fill all engines, fifth coordinate stalls
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_vld = 1'b1;
            bus.in_adr = fill_tbl[i].adr;
            bus.in_x   = fill_tbl[i].x;
            bus.in_y   = fill_tbl[i].y;
            check($sformatf("fill_rdy[%0d]", i), bus.in_rdy, fill_tbl[i].rdy);
            tick();
            check($sformatf("fill_start[%0d]", i), bus.eng_start, fill_tbl[i].start);
            if (fill_tbl[i].start != '0) begin
                check($sformatf("fill_x[%0d]", i), bus.eng_x, fill_tbl[i].x);
            end
        end
        finish_eng(4'b0100, 32'h0011_0000);
        check("fill_rdy_done", bus.in_rdy, 0);
        tick();
        check("fill_out_vld", bus.out_vld, 1);
        check("fill_out_adr", bus.out_adr, 2);
        check("fill_out_niter", bus.out_niter, 8'h11);
        check("fill_rdy_freed", bus.in_rdy, 1);
        tick();
        bus.in_vld = 1'b0;
        check("fill_redispatch", bus.eng_start, 4'b0100);
        check("fill_redispatch_x", bus.eng_x, fill_tbl[4].x);

        // Simultaneous completion with cp=2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(12'd10 + AW'(i), NE'(1 << i), $sformatf("simul_start[%0d]", i));
        end
        tick();
        finish_eng(4'b0001, 32'h0000_0030);
        tick();
        check("simul_pre0_adr", bus.out_adr, 10);
        finish_eng(4'b0010, 32'h0000_3100);
        tick();
        check("simul_pre1_adr", bus.out_adr, 11);
        dispatch(12'd20, 4'b0001, "simul_re0");
        dispatch(12'd21, 4'b0010, "simul_re1");
        tick();
        finish_eng(4'b1111, 32'h4342_4140);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("simul_vld[%0d]", i), bus.out_vld, 1);
            check($sformatf("simul_adr[%0d]", i), bus.out_adr, simul_tbl[i].adr);
            check($sformatf("simul_niter[%0d]", i), bus.out_niter, simul_tbl[i].niter);
        end
        tick();
        check("simul_vld_clr", bus.out_vld, 0);
        check("simul_err", err, 0);

        // Backpressure with four results pending
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(12'd30 + AW'(i), NE'(1 << i), $sformatf("bp_start[%0d]", i));
        end
        tick();
        bus.out_rdy = 1'b0;
        finish_eng(4'b1111, 32'h5352_5150);
        tick();
        dispatch(12'd34, 4'b0001, "bp_refill");
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp_hold[%0d]", i),
                  {bus.out_vld, bus.out_adr, bus.out_niter, bus.in_rdy},
                  {1'b1, drain_tbl[0].adr, drain_tbl[0].niter, 1'b0});
            tick();
        end
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_drain_vld[%0d]", i), bus.out_vld, 1);
            check($sformatf("bp_drain_adr[%0d]", i), bus.out_adr, drain_tbl[i].adr);
            check($sformatf("bp_drain_niter[%0d]", i), bus.out_niter, drain_tbl[i].niter);
            tick();
        end
        check("bp_drain_empty", bus.out_vld, 0);
        check("bp_err", err, 0);

        // Spurious completion on an idle engine
        do_reset();
        finish_eng(4'b1000, 32'h7700_0000);
        check("spur_err", err, 1);
        check("spur_vld", bus.out_vld, 0);
        repeat (3) tick();
        check("spur_err_sticky", err, 1);
        check("spur_vld_later", bus.out_vld, 0);

        // Reset mid-run
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(12'd40 + AW'(i), NE'(1 << i), $sformatf("mid_start[%0d]", i));
        end
        tick();
        bus.out_rdy = 1'b0;
        finish_eng(4'b1000, 32'h6600_0000);
        tick();
        check("mid_vld_before", bus.out_vld, 1);
        rst          = 1'b1;
        bus.eng_done = 4'b0111;
        #2;
        check("mid_start", bus.eng_start, 0);
        check("mid_x", bus.eng_x, 0);
        check("mid_vld", bus.out_vld, 0);
        check("mid_adr", bus.out_adr, 0);
        check("mid_niter", bus.out_niter, 0);
        check("mid_rdy", bus.in_rdy, 1);
        check("mid_busy", busy, 0);
        tick();
        bus.eng_done = '0;
        idle_inputs();
        tick();
        rst = 1'b0;
        check("mid_err", err, 0);
        dispatch(12'd50, 4'b0001, "mid_fresh");
        check("mid_fresh_x", bus.eng_x, 27'h0100000 + 27'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mandelbrot_dispatch.md
Name: mandelbrot_dispatch

Overview:
- Scheduler between the coordinate generator and NE parallel Mandelbrot iteration engines.
- Accepts one coordinate per handshake and hands it to an idle engine, round-robin.
- Keeps each engine's pixel address in an internal tag table.
- Collects iteration counts as engines finish and serializes them, round-robin, to the framebuffer writer as (adr, niter) pairs.

Parameters:
- NE, 4, number of iteration engines (2..16).
- FPW, 27, fixed-point coordinate width.
- AW, 12, pixel address width.
- IW, 8, iteration count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  clock enable; no state changes when low.
- in_vld  in  1  coordinate valid from generator.
- in_rdy  out  1  dispatcher can accept a coordinate.
- in_x  in  FPW  Mandelbrot x coordinate.
- in_y  in  FPW  Mandelbrot y coordinate.
- in_adr  in  AW  pixel address.
- eng_start  out  NE  one-hot start pulse, one enabled cycle.
- eng_x  out  FPW  shared x bus, valid while eng_start != 0.
- eng_y  out  FPW  shared y bus, valid while eng_start != 0.
- eng_done  in  NE  per-engine completion pulse.
- eng_niter  in  NE*IW  per-engine iteration count; slice k valid with eng_done[k].
- out_vld  out  1  result valid.
- out_rdy  in  1  result consumer ready.
- out_adr  out  AW  pixel address of result.
- out_niter  out  IW  iteration count of result.
- busy  out  1  any engine not IDLE, or out_vld high.
- err  out  1  sticky: eng_done seen on an engine not BUSY.

Behaviour:
- All state updates on posedge clk only when clk_en=1. Engines and consumer sample with the same clk_en.
- Per-engine state: IDLE -> BUSY -> DONE -> IDLE. Per-engine regs: tag_adr[AW], res_niter[IW].
- Reset values:
  - All engines IDLE; eng_start=0; eng_x=0; eng_y=0.
  - out_vld=0; out_adr=0; out_niter=0.
  - err=0; both round-robin pointers=0.
  - in_rdy is combinational = OR(state==IDLE), so it is 1 after reset. busy=0.
- Dispatch:
  - Transfer when in_vld && in_rdy && clk_en.
  - Selected engine k is the first IDLE index at or after dispatch pointer dp, wrapping modulo NE.
  - At the transfer edge: tag_adr[k]<=in_adr; eng_x/eng_y<=in_x/in_y; eng_start<=onehot(k); state[k]<=BUSY; dp<=(k+1) mod NE.
  - eng_start clears on the next enabled edge unless another transfer occurs. Back-to-back transfers to different engines are allowed every cycle.
  - in_rdy has no combinational path from in_vld.
- Completion:
  - eng_done[k] && state[k]==BUSY: res_niter[k]<=eng_niter slice k; state[k]<=DONE.
  - eng_done[k] in IDLE or DONE: ignored, err<=1 (sticky until rst).
  - eng_done in the same cycle as that engine's eng_start: treated as IDLE case.
- Collection:
  - Output register loads when !out_vld || out_rdy.
  - Source is the first DONE engine at or after collect pointer cp, mod NE.
  - On load: out_adr<=tag_adr[j]; out_niter<=res_niter[j]; out_vld<=1; state[j]<=IDLE; cp<=(j+1) mod NE.
  - No DONE engine and out_rdy: out_vld<=0.
  - An engine freed by collection is IDLE from the next cycle; in_rdy does not see it in the same cycle.
  - Throughput: one result per cycle with out_rdy held high.
- Latency:
  - Handshake edge N -> eng_start visible cycle N+1.
  - eng_done at edge M -> earliest out_vld at cycle M+2 (DONE registered at M+1, output loaded M+2).
- Ordering:
  - Results are in completion order, not address order.
  - Addresses travel with the result; the consumer must not assume raster order.
- Backpressure: out_rdy low holds out_* stable. Engines stay DONE; in_rdy drops once all are BUSY/DONE.
- Reset mid-operation: all in-flight work discarded, state as reset; later eng_done pulses set err only if rst has released.

Decomposition:
- Shared package mandelbrot_pkg:
  - Engine state encoding (ENG_IDLE=2'd0, ENG_BUSY=2'd1, ENG_DONE=2'd2).
  - Fixed-point split constants FP_S=1, FP_I=4, FP_F=FPW-5.
  - Default NE/IW.
- One sub-module, mandelbrot_rr_arb: combinational round-robin first-match (req[NE], ptr) -> grant onehot, index, any. Instanced twice: dispatch over IDLE, collect over DONE.

Test Plan:
- Single pixel: in x=0x3bd5555, y=0x3e00000, adr=5.
  - eng_start=0001 next cycle with eng_x/eng_y matching.
  - eng_done[0] niter=0x2a 10 cycles later -> out_vld, adr=5, niter=0x2a two cycles later.
  - busy=0 after out_rdy.
- Fill: 5 back-to-back coords, adr 0..4, all engines slow.
  - eng_start 0001, 0010, 0100, 1000 on consecutive cycles; in_rdy=0 before 5th.
  - Finishing engine 2 lets adr 4 go to engine 2.
- Simultaneous done: engines 0..3 done in the same cycle with cp=2.
  - Outputs in order engine 2, 3, 0, 1 with the correct adr/niter pairs.
- Backpressure: out_rdy=0 for 20 cycles with 4 results pending.
  - out_* stable, in_rdy=0.
  - Releasing out_rdy drains 4 results in 4 consecutive cycles.
- Spurious done: eng_done[3] while engine 3 IDLE -> err=1 and stays 1; no out_vld.
- Reset mid-run: rst with 3 engines BUSY and out_vld=1.
  - All outputs zero, in_rdy=1, busy=0.
  - Fresh dispatch starts at engine 0.
